// File: rtl/cva5_config.sv
// Core-wide configuration constants shared by the writeback path.
package cva5_config;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned ID_W         = 3;
  localparam int unsigned NUM_WB_UNITS = 4;

endpackage

// File: rtl/cva5_types.sv
// Shared payload types for the unit writeback interface.
package cva5_types;

  // One captured writeback beat: instruction ID plus result data.
  typedef struct packed {
    logic [cva5_config::ID_W-1:0] id;
    logic [cva5_config::XLEN-1:0] data;
  } wb_result_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Writeback source arbiter: one-hot grant plus binary grant index.
// WB_ROUND_ROBIN_EN selects round-robin with a rotating priority pointer;
// without it, fixed priority (lowest index wins) and no pointer register.
module wb_rr_arbiter
  import cva5_types::*;
#(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned IDX_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_UNITS-1:0] req,
  input  logic                 advance,
  output logic [NUM_UNITS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  if (NUM_UNITS == 1) begin : g_single
    // A single source needs no policy and no pointer.
    logic unused_ok;
    assign unused_ok = ^{clk, rst, advance};
    assign grant     = req;
    assign grant_idx = '0;
  end else begin : g_multi
`ifdef WB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;
    int unsigned      idx;
    logic             found;

    // Search requests starting at the pointer, wrapping cyclically.
    always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
        idx = (32'(ptr) + k) % NUM_UNITS;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = IDX_W'(idx);
        end
      end
    end

    // Pointer moves just past the winner whenever a grant is consumed.
    always_ff @(posedge clk) begin
      if (!rst) begin
        ptr <= '0;
      end else if (advance && (|req)) begin
        ptr <= (grant_idx == IDX_W'(NUM_UNITS - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
    end
`else
    logic unused_ok;
    logic found;
    assign unused_ok = ^{clk, rst, advance};

    // Lowest-index requester wins.
    always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        if (!found && req[i]) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end
`endif
  end

endmodule

// File: rtl/writeback_collector.sv
// Collects completed results from the execution units, acknowledges one per
// cycle, and presents it on a single registered writeback port with
// backpressure. Arbitration policy is chosen by WB_ROUND_ROBIN_EN
// (round-robin when defined, fixed priority otherwise).
module writeback_collector
  import cva5_types::*;
#(
  parameter int unsigned NUM_UNITS = cva5_config::NUM_WB_UNITS,
  parameter int unsigned XLEN      = cva5_config::XLEN,
  parameter int unsigned ID_W      = cva5_config::ID_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_UNITS-1:0]      unit_done,
  input  logic [NUM_UNITS*ID_W-1:0] unit_id,
  input  logic [NUM_UNITS*XLEN-1:0] unit_rd,
  output logic [NUM_UNITS-1:0]      unit_ack,
  output logic                      wb_valid,
  output logic [ID_W-1:0]           wb_id,
  output logic [XLEN-1:0]           wb_data,
  input  logic                      wb_ready
);

  localparam int unsigned IDX_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int unsigned PKG_ID_W = cva5_config::ID_W;
  localparam int unsigned PKG_XLEN = cva5_config::XLEN;

  logic                 load_en;
  logic [NUM_UNITS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  wb_result_t           sel_result;
  wb_result_t           res_q;

  // Output register is empty or being drained this cycle.
  assign load_en = !wb_valid || wb_ready;

  wb_rr_arbiter #(
    .NUM_UNITS (NUM_UNITS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (unit_done),
    .advance   (load_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Ack only when the beat is actually captured; never during reset.
  assign unit_ack = (rst && load_en) ? grant : '0;

  // Select the winning unit's ID and data.
  always_comb begin
    sel_result      = '0;
    sel_result.id   = PKG_ID_W'(unit_id[32'(grant_idx)*ID_W +: ID_W]);
    sel_result.data = PKG_XLEN'(unit_rd[32'(grant_idx)*XLEN +: XLEN]);
  end

  // One-entry output register; loads when empty or draining.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      res_q    <= '0;
    end else if (load_en) begin
      wb_valid <= |unit_done;
      if (|unit_done) begin
        res_q <= sel_result;
      end
    end
  end

  assign wb_id   = ID_W'(res_q.id);
  assign wb_data = XLEN'(res_q.data);

endmodule

// File: tb/tb_writeback_collector.sv
// Directed self-checking bench for writeback_collector (4 units, XLEN 32, ID_W 3).
// Ack order expectations follow WB_ROUND_ROBIN_EN when it is defined.
module tb_writeback_collector;

  logic         clk;
  logic         rst;
  logic [3:0]   unit_done;
  logic [11:0]  unit_id;
  logic [127:0] unit_rd;
  logic [3:0]   unit_ack;
  logic         wb_valid;
  logic [2:0]   wb_id;
  logic [31:0]  wb_data;
  logic         wb_ready;

  int tests;
  int fails;

  writeback_collector #(
    .NUM_UNITS (4),
    .XLEN      (32),
    .ID_W      (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .unit_done (unit_done),
    .unit_id   (unit_id),
    .unit_rd   (unit_rd),
    .unit_ack  (unit_ack),
    .wb_valid  (wb_valid),
    .wb_id     (wb_id),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int u, input logic [2:0] id, input logic [31:0] rd);
    unit_id[u*3 +: 3]   = id;
    unit_rd[u*32 +: 32] = rd;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    unit_done = 4'b0000;
    wb_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    wb_ready = 1'b1;
    for (int u = 0; u < 4; u++) set_unit(u, 3'(u + 4), 32'hA000_0000 + 32'(u));
    unit_done = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      tests++; if (unit_ack !== 4'b0000) begin fails++; $display("FAIL reset_ack: got %b expected 0000", unit_ack); end
      tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", wb_valid); end
      tests++; if (wb_id !== 3'd0) begin fails++; $display("FAIL reset_id: got %0d expected 0", wb_id); end
      tests++; if (wb_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", wb_data); end
    end
    rst = 1'b1;
    #1;
    tests++; if (unit_ack !== 4'b0001) begin fails++; $display("FAIL release_ack: got %b expected 0001", unit_ack); end
    tick();
    #1;
    tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL release_valid: got %b expected 1", wb_valid); end
    tests++; if (wb_id !== 3'd4) begin fails++; $display("FAIL release_id: got %0d expected 4", wb_id); end
    tests++; if (wb_data !== 32'hA000_0000) begin fails++; $display("FAIL release_data: got %h expected a0000000", wb_data); end
    // Reset while a beat is pending: it must be discarded and no ack issued.
    unit_done = 4'b1110;
    rst       = 1'b0;
    #1;
    tests++; if (unit_ack !== 4'b0000) begin fails++; $display("FAIL midreset_ack: got %b expected 0000", unit_ack); end
    tick();
    #1;
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b expected 0", wb_valid); end
    rst       = 1'b1;
    unit_done = 4'b0000;
  endtask

  task automatic test_single();
    do_reset();
    set_unit(2, 3'd5, 32'hDEAD_BEEF);
    unit_done = 4'b0100;
    wb_ready  = 1'b1;
    #1;
    tests++; if (unit_ack !== 4'b0100) begin fails++; $display("FAIL single_ack: got %b expected 0100", unit_ack); end
    tick();
    unit_done = 4'b0000;
    #1;
    tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", wb_valid); end
    tests++; if (wb_id !== 3'd5) begin fails++; $display("FAIL single_id: got %0d expected 5", wb_id); end
    tests++; if (wb_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL single_data: got %h expected deadbeef", wb_data); end
    tests++; if (unit_ack !== 4'b0000) begin fails++; $display("FAIL single_noack: got %b expected 0000", unit_ack); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_unit(3, 3'd3, 32'h3333_3333);
    set_unit(1, 3'd1, 32'h1111_1111);
    unit_done = 4'b1000;
    wb_ready  = 1'b1;
    #1;
    tests++; if (unit_ack !== 4'b1000) begin fails++; $display("FAIL bp_first_ack: got %b expected 1000", unit_ack); end
    tick();
    unit_done = 4'b0010;
    wb_ready  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if (unit_ack !== 4'b0000) begin fails++; $display("FAIL bp_ack cycle %0d: got %b expected 0000", c, unit_ack); end
      tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL bp_valid cycle %0d: got %b expected 1", c, wb_valid); end
      tests++; if (wb_id !== 3'd3) begin fails++; $display("FAIL bp_id cycle %0d: got %0d expected 3", c, wb_id); end
      tests++; if (wb_data !== 32'h3333_3333) begin fails++; $display("FAIL bp_data cycle %0d: got %h expected 33333333", c, wb_data); end
      tick();
    end
    wb_ready = 1'b1;
    #1;
    tests++; if (unit_ack !== 4'b0010) begin fails++; $display("FAIL bp_release_ack: got %b expected 0010", unit_ack); end
    tick();
    unit_done = 4'b0000;
    #1;
    tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL bp_next_valid: got %b expected 1", wb_valid); end
    tests++; if (wb_id !== 3'd1) begin fails++; $display("FAIL bp_next_id: got %0d expected 1", wb_id); end
    tests++; if (wb_data !== 32'h1111_1111) begin fails++; $display("FAIL bp_next_data: got %h expected 11111111", wb_data); end
  endtask

  task automatic test_arbitration();
    int exp_u;
    int prev_u;
    do_reset();
    for (int u = 0; u < 4; u++) set_unit(u, 3'(u + 4), 32'hC000_0000 + 32'(u));
    unit_done = 4'b1111;
    wb_ready  = 1'b1;
    prev_u    = 0;
    for (int k = 0; k < 5; k++) begin
`ifdef WB_ROUND_ROBIN_EN
      exp_u = k % 4;
`else
      exp_u = 0;
`endif
      #1;
      tests++; if (unit_ack !== 4'(1 << exp_u)) begin fails++; $display("FAIL arb_ack step %0d: got %b expected unit %0d", k, unit_ack, exp_u); end
      if (k > 0) begin
        tests++; if (wb_id !== 3'(prev_u + 4)) begin fails++; $display("FAIL arb_id step %0d: got %0d expected %0d", k, wb_id, prev_u + 4); end
        tests++; if (wb_data !== 32'hC000_0000 + 32'(prev_u)) begin fails++; $display("FAIL arb_data step %0d: got %h expected unit %0d data", k, wb_data, prev_u); end
      end
      prev_u = exp_u;
      tick();
    end
    unit_done = 4'b0000;
  endtask

  task automatic test_idle_drain();
    do_reset();
    set_unit(0, 3'd2, 32'h1234_5678);
    unit_done = 4'b0001;
    wb_ready  = 1'b1;
    #1;
    tests++; if (unit_ack !== 4'b0001) begin fails++; $display("FAIL drain_ack: got %b expected 0001", unit_ack); end
    tick();
    unit_done = 4'b0000;
    #1;
    tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL drain_valid_hi: got %b expected 1", wb_valid); end
    tests++; if (wb_data !== 32'h1234_5678) begin fails++; $display("FAIL drain_data: got %h expected 12345678", wb_data); end
    tick();
    #1;
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL drain_valid_lo: got %b expected 0", wb_valid); end
    tests++; if (unit_ack !== 4'b0000) begin fails++; $display("FAIL drain_noack: got %b expected 0000", unit_ack); end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b0;
    unit_done = 4'b0000;
    unit_id   = '0;
    unit_rd   = '0;
    wb_ready  = 1'b1;
    #2;
    test_reset();
    test_single();
    test_backpressure();
    test_arbitration();
    test_idle_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_collector.md
Name: writeback_collector

Overview:
- Consumer end of the unit writeback interface.
- Accepts completed results from NUM_UNITS execution units (ALU, mul, div, CSR, ...), each of which holds done/id/rd stable.
- Arbitrates one result per cycle, acknowledges the winning unit, and registers the result into a single writeback port toward the register file / ID-tracking logic.
- Supports downstream backpressure through a one-entry output register.

Parameters:
- NUM_UNITS, 4, number of writeback sources (minimum 1).
- XLEN, 32, result width.
- ID_W, 3, instruction ID width (log2 of maximum in-flight IDs).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the rising clk edge).
- unit_done  in  NUM_UNITS  per-unit result-valid; held high until acked.
- unit_id  in  NUM_UNITS*ID_W  per-unit instruction ID; stable while done.
- unit_rd  in  NUM_UNITS*XLEN  per-unit result data; stable while done.
- unit_ack  out  NUM_UNITS  one-hot, combinational; high in the cycle the unit's result is captured.
- wb_valid  out  1  registered result valid.
- wb_id  out  ID_W  registered instruction ID.
- wb_data  out  XLEN  registered result.
- wb_ready  in  1  downstream accepts the wb_* beat this cycle.

Behaviour:
- load_en = !wb_valid | wb_ready. The output register is empty or draining this cycle.
- Grant, combinational:
  - When load_en=1 and |unit_done, exactly one bit of grant is set, chosen by the arbitration policy (see Optional Feature).
  - unit_ack = grant when load_en=1; otherwise unit_ack = 0.
  - unit_ack is forced 0 while rst=0.
- Output register, on clk edge:
  - If load_en: wb_valid <= |unit_done; if any unit is granted, wb_id <= unit_id[g] and wb_data <= unit_rd[g].
  - If !load_en: all wb_* hold.
- Latency: one cycle from ack to wb_valid. Back-to-back results at one per cycle with wb_ready=1.
- Handshake:
  - A unit sees unit_ack high in the same cycle it is captured.
  - The unit may drop done, or present the next result, on the following cycle.
  - A unit with done=1 and no ack must keep its id/rd unchanged.
- Backpressure: while wb_valid=1 and wb_ready=0:
  - No acks are issued.
  - The wb_* outputs are held stable.
  - The arbitration pointer is unchanged.
- Simultaneous drain and load: when wb_valid=1, wb_ready=1 and a unit is done, the new result replaces the old one in the same edge. There is no bubble.
- No done and load_en=1: wb_valid <= 0. wb_id and wb_data hold their last values (don't-care).
- Reset values: wb_valid=0, wb_id=0, wb_data=0, arbitration pointer=0.
- Reset mid-operation: a pending, un-drained output beat is discarded. Units see no ack during reset and keep done asserted.
- NUM_UNITS=1: grant = unit_done & load_en. The pointer logic is removed.

Optional Feature:
- Macro WB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration. A pointer register (clog2(NUM_UNITS) bits, reset 0) gives the highest-priority index; priority descends cyclically from the pointer.
  - On any ack to unit g, pointer <= (g+1) mod NUM_UNITS. The pointer holds when there is no ack.
- Undefined:
  - Fixed priority: the lowest-index done unit wins. No pointer register is instantiated.
  - A continuously done unit 0 starves the others.

Decomposition:
- Package (cva5_types): wb_result_t struct {id[ID_W], data[XLEN]}. XLEN and the ID width come from cva5_config.
- Sub-module: wb_rr_arbiter.
  - Inputs: request vector, advance.
  - Outputs: one-hot grant, grant index.
  - Contains the pointer and the policy, so the macro selects its internals.
- The collector contains the load_en logic, the data mux and the output register.

Test Plan:
- Reset: hold rst=0 for 2 cycles with unit_done=4'b1111 -> unit_ack=0, wb_valid=0, wb_id=0, wb_data=0. First cycle after release: exactly one ack. wb_valid=1 on the next edge.
- Single source: unit 2 done, id=5, rd=32'hDEADBEEF, wb_ready=1 -> unit_ack=4'b0100 in that cycle. Next cycle wb_valid=1, wb_id=5, wb_data=32'hDEADBEEF.
- Backpressure: with wb_valid=1, hold wb_ready=0 for 3 cycles while unit 1 is done -> unit_ack=0 and wb_* stable. When wb_ready=1, unit 1 is acked the same cycle and its data appears on the next edge with no bubble.
- Round-robin (WB_ROUND_ROBIN_EN): all 4 units done continuously, wb_ready=1 -> ack order 0,1,2,3,0 and each wb_id matches its unit.
- Fixed priority (macro undefined): same stimulus as the round-robin case -> unit 0 is acked every cycle and units 1-3 are never acked.
- Idle drain: one result, then unit_done=0 with wb_ready=1 -> wb_valid falls to 0 one cycle after the beat is accepted.
